ctrl_word_sequencer: RTL and testbench

// Source end of the CTRL_Signal interface: fetches packed instruction words from a 1-cycle-latency

---
 rtl/ctrl_word_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_ctrl_word_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_word_sequencer.sv
// Streams packed {last, rep, ctrl} instruction words from a 1-cycle-latency BRAM onto CTRL_Signal.
// Optional issue/stall performance counters are built when CTRL_SEQ_PERF_CNT_EN is defined.
module ctrl_word_sequencer #(
   parameter int CTRL_WIDTH       = 60,
   parameter int INSTR_ADDR_WIDTH = 10,
   parameter int REP_WIDTH        = 8
) (
   input  logic                          CLK_100,
   input  logic                          locked,
   input  logic                          start,
   input  logic [INSTR_ADDR_WIDTH-1:0]   start_addr,
   input  logic                          pause,
   output logic [INSTR_ADDR_WIDTH-1:0]   instr_addr,
   output logic                          instr_en,
   input  logic [CTRL_WIDTH+REP_WIDTH:0] instr_dout,
   output logic [CTRL_WIDTH-1:0]         CTRL_Signal,
   output logic                          busy,
   output logic                          done
`ifdef CTRL_SEQ_PERF_CNT_EN
   ,
   output logic [31:0]                   issue_cycles,
   output logic [31:0]                   stall_cycles
`endif
);

   localparam int INSTR_WIDTH = CTRL_WIDTH + REP_WIDTH + 1;

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_ISSUE, S_DONE} state_t;

   state_t                        state_reg, state_next;
   logic                          fetching_reg, fetching_next;
   logic [INSTR_ADDR_WIDTH-1:0]   addr_reg, addr_next;
   logic                          rd_pending_reg;
   logic [INSTR_WIDTH-1:0]        slot_reg [2];
   logic [INSTR_WIDTH-1:0]        slot_next [2];
   logic [1:0]                    count_reg, count_next;
   logic [CTRL_WIDTH-1:0]         cur_ctrl_reg, cur_ctrl_next;
   logic [REP_WIDTH-1:0]          cur_rep_reg, cur_rep_next;
   logic                          cur_last_reg, cur_last_next;
   logic                          cur_valid_reg, cur_valid_next;
   logic [REP_WIDTH-1:0]          rep_cnt_reg, rep_cnt_next;
   logic [CTRL_WIDTH-1:0]         ctrl_reg, ctrl_next;

   logic                   active, step, avail, word_done;
   logic                   repeat_cur, finish, load, push, pop, last_arrive;
   logic [INSTR_WIDTH-1:0] head;
   logic [2:0]             occ;

   assign active      = (state_reg == S_FILL) || (state_reg == S_ISSUE);
   assign step        = active && !pause;
   assign avail       = (count_reg != 2'd0) || rd_pending_reg;
   // Buffer empty: the word arriving from the BRAM this cycle bypasses straight to the output.
   assign head        = (count_reg != 2'd0) ? slot_reg[0] : instr_dout;
   assign word_done   = cur_valid_reg && (rep_cnt_reg == cur_rep_reg);
   assign repeat_cur  = step && cur_valid_reg && !word_done;
   assign finish      = step && word_done && cur_last_reg;
   assign load        = step && !repeat_cur && !finish && avail;
   assign pop         = load && (count_reg != 2'd0);
   assign push        = rd_pending_reg && !(load && (count_reg == 2'd0));
   assign last_arrive = rd_pending_reg && instr_dout[INSTR_WIDTH-1];

   // Slots already committed (stored or in flight) after this cycle's consumption.
   assign occ      = {1'b0, count_reg} + {2'b00, rd_pending_reg} - {2'b00, load};
   assign instr_en = fetching_reg && (occ <= 3'd1) && !last_arrive;

   assign instr_addr  = addr_reg;
   assign CTRL_Signal = ctrl_reg;
   assign busy        = (state_reg != S_IDLE);
   assign done        = (state_reg == S_DONE);

   always_comb begin
      state_next     = state_reg;
      fetching_next  = fetching_reg;
      addr_next      = addr_reg;
      count_next     = count_reg;
      slot_next[0]   = slot_reg[0];
      slot_next[1]   = slot_reg[1];
      cur_ctrl_next  = cur_ctrl_reg;
      cur_rep_next   = cur_rep_reg;
      cur_last_next  = cur_last_reg;
      cur_valid_next = cur_valid_reg;
      rep_cnt_next   = rep_cnt_reg;
      ctrl_next      = '0;

      if (pop) begin
         slot_next[0] = slot_reg[1];
         if (push) begin
            if (count_reg == 2'd1) slot_next[0] = instr_dout;
            else                   slot_next[1] = instr_dout;
         end else begin
            count_next = count_reg - 2'd1;
         end
      end else if (push) begin
         if (count_reg == 2'd0) slot_next[0] = instr_dout;
         else                   slot_next[1] = instr_dout;
         count_next = count_reg + 2'd1;
      end

      if (instr_en)    addr_next     = addr_reg + 1'b1;
      if (last_arrive) fetching_next = 1'b0;

      if (repeat_cur) begin
         ctrl_next    = cur_ctrl_reg;
         rep_cnt_next = rep_cnt_reg + 1'b1;
      end else if (finish) begin
         cur_valid_next = 1'b0;
      end else if (load) begin
         ctrl_next      = head[CTRL_WIDTH-1:0];
         cur_ctrl_next  = head[CTRL_WIDTH-1:0];
         cur_rep_next   = head[INSTR_WIDTH-2:CTRL_WIDTH];
         cur_last_next  = head[INSTR_WIDTH-1];
         cur_valid_next = 1'b1;
         rep_cnt_next   = '0;
      end

      case (state_reg)
         S_IDLE: begin
            if (start) begin
               state_next     = S_FILL;
               fetching_next  = 1'b1;
               addr_next      = start_addr;
               count_next     = 2'd0;
               cur_valid_next = 1'b0;
               rep_cnt_next   = '0;
            end
         end
         S_FILL:  if (load)   state_next = S_ISSUE;
         S_ISSUE: if (finish) state_next = S_DONE;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK_100 or negedge locked) begin
      if (!locked) begin
         state_reg      <= S_IDLE;
         fetching_reg   <= 1'b0;
         addr_reg       <= '0;
         rd_pending_reg <= 1'b0;
         count_reg      <= 2'd0;
         for (int i = 0; i < 2; i++) slot_reg[i] <= '0;
         cur_ctrl_reg   <= '0;
         cur_rep_reg    <= '0;
         cur_last_reg   <= 1'b0;
         cur_valid_reg  <= 1'b0;
         rep_cnt_reg    <= '0;
         ctrl_reg       <= '0;
      end else begin
         state_reg      <= state_next;
         fetching_reg   <= fetching_next;
         addr_reg       <= addr_next;
         rd_pending_reg <= instr_en;
         count_reg      <= count_next;
         for (int i = 0; i < 2; i++) slot_reg[i] <= slot_next[i];
         cur_ctrl_reg   <= cur_ctrl_next;
         cur_rep_reg    <= cur_rep_next;
         cur_last_reg   <= cur_last_next;
         cur_valid_reg  <= cur_valid_next;
         rep_cnt_reg    <= rep_cnt_next;
         ctrl_reg       <= ctrl_next;
      end
   end

`ifdef CTRL_SEQ_PERF_CNT_EN
   logic [31:0] issue_cycles_reg, stall_cycles_reg;

   assign issue_cycles = issue_cycles_reg;
   assign stall_cycles = stall_cycles_reg;

   always_ff @(posedge CLK_100 or negedge locked) begin
      if (!locked) begin
         issue_cycles_reg <= '0;
         stall_cycles_reg <= '0;
      end else if (start && (state_reg == S_IDLE)) begin
         issue_cycles_reg <= '0;
         stall_cycles_reg <= '0;
      end else begin
         if ((ctrl_reg != '0) && (issue_cycles_reg != 32'hFFFF_FFFF))
            issue_cycles_reg <= issue_cycles_reg + 32'd1;
         if (busy && pause && (stall_cycles_reg != 32'hFFFF_FFFF))
            stall_cycles_reg <= stall_cycles_reg + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ctrl_word_sequencer.sv
// Scoreboard bench for ctrl_word_sequencer: expected per-cycle CTRL_Signal/done stream is queued
// by the stimulus and popped by a monitor on every busy cycle; BRAM reads are logged and checked.
`timescale 1ns/1ps
module tb_ctrl_word_sequencer;
   localparam int CW = 60;
   localparam int AW = 10;
   localparam int RW = 8;
   localparam int IW = CW + RW + 1;

   logic          CLK_100 = 1'b0;
   logic          locked = 1'b0;
   logic          start = 1'b0;
   logic          pause = 1'b0;
   logic [AW-1:0] start_addr = '0;
   logic [AW-1:0] instr_addr;
   logic          instr_en;
   logic [IW-1:0] instr_dout = '0;
   logic [CW-1:0] CTRL_Signal;
   logic          busy, done;
`ifdef CTRL_SEQ_PERF_CNT_EN
   logic [31:0]   issue_cycles, stall_cycles;
`endif

   always #5 CLK_100 = ~CLK_100;

   ctrl_word_sequencer #(.CTRL_WIDTH(CW), .INSTR_ADDR_WIDTH(AW), .REP_WIDTH(RW)) dut (
      .CLK_100(CLK_100), .locked(locked), .start(start), .start_addr(start_addr), .pause(pause),
      .instr_addr(instr_addr), .instr_en(instr_en), .instr_dout(instr_dout),
      .CTRL_Signal(CTRL_Signal), .busy(busy), .done(done)
`ifdef CTRL_SEQ_PERF_CNT_EN
      , .issue_cycles(issue_cycles), .stall_cycles(stall_cycles)
`endif
   );

   // Instruction BRAM model with registered read; every read address is logged.
   logic [IW-1:0] mem [1 << AW];
   logic [AW-1:0] rd_log [$];
   logic [AW-1:0] exp_rd [$];
   always @(posedge CLK_100) begin
      if (instr_en) begin
         instr_dout <= mem[instr_addr];
         rd_log.push_back(instr_addr);
      end
   end

   typedef struct packed {
      logic          d;
      logic [CW-1:0] c;
   } exp_t;
   exp_t sb [$];

   int n_vec = 0;
   int n_err = 0;
   int done_cnt = 0;
   int done_base = 0;

   localparam logic [CW-1:0] A = 60'hA00_0000_0000_0001;
   localparam logic [CW-1:0] B = 60'h0B0_0000_1000_0002;
   localparam logic [CW-1:0] C = 60'h00C_0000_0000_0003;
   localparam logic [CW-1:0] D = 60'h0D0_0000_0000_0004;
   localparam logic [CW-1:0] E = 60'hE00_0000_0000_0005;
   localparam logic [CW-1:0] F = 60'h0F0_0000_0000_0006;
   localparam logic [CW-1:0] G = 60'h006_0000_0000_0007;
   localparam logic [CW-1:0] H = 60'h808_0000_0000_0008;
   localparam logic [CW-1:0] I = 60'h001_0000_0000_0009;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: one expected entry per busy cycle.
   always @(negedge CLK_100) begin
      if (locked) begin
         if (done) done_cnt++;
         if (busy) begin
            if (sb.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL stream_extra: got ctrl %0h done %0b expected no busy cycle", CTRL_Signal, done);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("stream", {3'b000, done, CTRL_Signal}, {3'b000, e});
            end
         end
      end
   end

   task automatic put(input int a, input logic [CW-1:0] c, input int rep, input bit last);
      logic [RW-1:0] r;
      logic [AW-1:0] ad;
      r  = rep[RW-1:0];
      ad = a[AW-1:0];
      mem[ad] = {last, r, c};
   endtask

   task automatic ex(input logic [CW-1:0] c, input int n, input bit d);
      exp_t e;
      e.d = d;
      e.c = c;
      for (int k = 0; k < n; k++) sb.push_back(e);
   endtask

   task automatic go(input logic [AW-1:0] a);
      @(negedge CLK_100);
      done_base  = done_cnt;
      start      = 1'b1;
      start_addr = a;
      @(negedge CLK_100);
      start = 1'b0;
   endtask

   task automatic finish_prog(input string name, input int budget);
      int k;
      k = 0;
      while (busy && k < budget) begin
         @(negedge CLK_100);
         k++;
      end
      if (busy) begin
         n_vec++;
         n_err++;
         $display("FAIL %s_timeout: got busy=1 after %0d cycles expected busy=0", name, budget);
      end
      chk({name, "_sb_left"}, 64'(sb.size()), 64'd0);
      chk({name, "_done_pulses"}, 64'(done_cnt - done_base), 64'd1);
      chk({name, "_nreads"}, 64'(rd_log.size()), 64'(exp_rd.size()));
      for (int j = 0; j < exp_rd.size(); j++)
         if (j < rd_log.size()) chk({name, "_rd_addr"}, 64'(rd_log[j]), 64'(exp_rd[j]));
      $display("prog %s: %0d reads, %0d done pulses", name, rd_log.size(), done_cnt - done_base);
      sb.delete();
      rd_log.delete();
      exp_rd.delete();
   endtask

   task automatic basic_prog();
      ex('0, 2, 1'b0); ex(A, 1, 1'b0); ex(B, 3, 1'b0); ex(C, 1, 1'b0); ex('0, 1, 1'b1);
      exp_rd.push_back(10'd5); exp_rd.push_back(10'd6); exp_rd.push_back(10'd7);
      go(10'd5);
      finish_prog("basic", 50);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      put(5, A, 0, 1'b0);    put(6, B, 2, 1'b0);  put(7, C, 0, 1'b1);
      put(1023, D, 0, 1'b0); put(0, E, 0, 1'b1);
      put(20, F, 3, 1'b0);   put(21, G, 0, 1'b1);
      put(40, H, 255, 1'b0); put(41, I, 0, 1'b1);

      repeat (3) @(negedge CLK_100);
      chk("rst_ctrl", 64'(CTRL_Signal), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_en", 64'(instr_en), 64'd0);
      chk("rst_addr", 64'(instr_addr), 64'd0);
      locked = 1'b1;
      repeat (2) @(negedge CLK_100);

      basic_prog();

      // Pause over cycles 5..7: interrupted B resumes with its remaining repeat.
      ex('0, 2, 1'b0); ex(A, 1, 1'b0); ex(B, 2, 1'b0); ex('0, 3, 1'b0);
      ex(B, 1, 1'b0); ex(C, 1, 1'b0); ex('0, 1, 1'b1);
      exp_rd.push_back(10'd5); exp_rd.push_back(10'd6); exp_rd.push_back(10'd7);
      go(10'd5);
      repeat (4) @(negedge CLK_100);
      pause = 1'b1;
      repeat (3) @(negedge CLK_100);
      pause = 1'b0;
      finish_prog("pause", 50);
`ifdef CTRL_SEQ_PERF_CNT_EN
      chk("perf_issue", 64'(issue_cycles), 64'd5);
      chk("perf_stall", 64'(stall_cycles), 64'd3);
      repeat (3) @(negedge CLK_100);
      chk("perf_issue_hold", 64'(issue_cycles), 64'd5);
      chk("perf_stall_hold", 64'(stall_cycles), 64'd3);
`endif

      // Address wrap 1023 -> 0, back-to-back single-cycle words.
      ex('0, 2, 1'b0); ex(D, 1, 1'b0); ex(E, 1, 1'b0); ex('0, 1, 1'b1);
      exp_rd.push_back(10'd1023); exp_rd.push_back(10'd0);
      go(10'd1023);
      finish_prog("wrap", 50);

      // Second start while busy must be ignored.
      ex('0, 2, 1'b0); ex(F, 4, 1'b0); ex(G, 1, 1'b0); ex('0, 1, 1'b1);
      exp_rd.push_back(10'd20); exp_rd.push_back(10'd21);
      go(10'd20);
      repeat (2) @(negedge CLK_100);
      start = 1'b1;
      start_addr = 10'd5;
      @(negedge CLK_100);
      start = 1'b0;
      finish_prog("start_busy", 50);

      // Start with pause held: buffer fills, issue waits for pause to drop.
      ex('0, 4, 1'b0); ex(A, 1, 1'b0); ex(B, 3, 1'b0); ex(C, 1, 1'b0); ex('0, 1, 1'b1);
      exp_rd.push_back(10'd5); exp_rd.push_back(10'd6); exp_rd.push_back(10'd7);
      pause = 1'b1;
      go(10'd5);
      repeat (3) @(negedge CLK_100);
      pause = 1'b0;
      finish_prog("start_paused", 50);

      // Maximum repeat field: 256 cycles of H.
      ex('0, 2, 1'b0); ex(H, 256, 1'b0); ex(I, 1, 1'b0); ex('0, 1, 1'b1);
      exp_rd.push_back(10'd40); exp_rd.push_back(10'd41);
      go(10'd40);
      finish_prog("rep_max", 400);

      // Asynchronous reset in the middle of issue aborts without a done pulse.
      ex('0, 2, 1'b0); ex(A, 1, 1'b0); ex(B, 3, 1'b0); ex(C, 1, 1'b0); ex('0, 1, 1'b1);
      go(10'd5);
      repeat (2) @(negedge CLK_100);
      #2 locked = 1'b0;
      #1;
      chk("abort_ctrl", 64'(CTRL_Signal), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_en", 64'(instr_en), 64'd0);
      sb.delete();
      repeat (3) @(negedge CLK_100);
      locked = 1'b1;
      repeat (12) @(negedge CLK_100);
      chk("abort_no_done", 64'(done_cnt - done_base), 64'd0);
      chk("abort_idle", 64'(busy), 64'd0);
      $display("prog abort: reset applied mid-issue");
      rd_log.delete();

      basic_prog();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
